// File: rtl/mini_src_cpu_top.sv
// mini_src_cpu_top: Mini SRC CPU datapath core.
// 16x32 general-purpose register file plus PC, IR, HI, LO, Z_HI, Z_LO and MDR,
// all muxed onto one combinational 32-bit bus.
// Optional feature macro: CPU_TOP_PC_INC_EN adds an inc_pc input that steps PC by one.
module mini_src_cpu_top (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [3:0]  addr_in,
   input  logic [3:0]  addr_out,
   input  logic [31:0] data_in,
   input  logic [4:0]  reg_out_select,
   input  logic        e_PC,
   input  logic        e_IR,
   input  logic        e_HI,
   input  logic        e_LO,
   input  logic        e_ZHI,
   input  logic        e_ZLO,
   input  logic        e_MDR,
`ifdef CPU_TOP_PC_INC_EN
   input  logic        inc_pc,
`endif
   output logic [31:0] bus_out
);

   logic [31:0] gpr [16];
   logic [31:0] pc_q, ir_q, hi_q, lo_q, zhi_q, zlo_q, mdr_q;

   // Register file write port; R0 is an ordinary register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
      end else if (load) begin
         gpr[addr_in] <= data_in;
      end
   end

   // Special registers; enables are independent, all load the shared data_in.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ir_q  <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         zhi_q <= '0;
         zlo_q <= '0;
         mdr_q <= '0;
      end else begin
         if (e_IR)  ir_q  <= data_in;
         if (e_HI)  hi_q  <= data_in;
         if (e_LO)  lo_q  <= data_in;
         if (e_ZHI) zhi_q <= data_in;
         if (e_ZLO) zlo_q <= data_in;
         if (e_MDR) mdr_q <= data_in;
      end
   end

   // Program counter; an explicit load takes precedence over the increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= '0;
      end else if (e_PC) begin
         pc_q <= data_in;
`ifdef CPU_TOP_PC_INC_EN
      end else if (inc_pc) begin
         pc_q <= pc_q + 32'd1;
`endif
      end
   end

   // Bus multiplexer; any code below 16 selects the register-file read port.
   always_comb begin
      bus_out = '0;
      casez (reg_out_select)
         5'b0????: bus_out = gpr[addr_out];
         5'd16:    bus_out = hi_q;
         5'd17:    bus_out = lo_q;
         5'd18:    bus_out = zhi_q;
         5'd19:    bus_out = zlo_q;
         5'd20:    bus_out = pc_q;
         5'd21:    bus_out = ir_q;
         5'd22:    bus_out = mdr_q;
         5'd23:    bus_out = data_in;
         default:  bus_out = '0;
      endcase
   end

endmodule

// File: tb/tb_mini_src_cpu_top.sv
// Directed self-checking bench for mini_src_cpu_top.
module tb_mini_src_cpu_top;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [3:0]  addr_in = '0;
   logic [3:0]  addr_out = '0;
   logic [31:0] data_in = '0;
   logic [4:0]  reg_out_select = '0;
   logic        e_PC = 1'b0, e_IR = 1'b0, e_HI = 1'b0, e_LO = 1'b0;
   logic        e_ZHI = 1'b0, e_ZLO = 1'b0, e_MDR = 1'b0;
`ifdef CPU_TOP_PC_INC_EN
   logic        inc_pc = 1'b0;
`endif
   logic [31:0] bus_out;

   int pass_cnt = 0;
   int total_cnt = 0;

   mini_src_cpu_top dut (
      .clk(clk),
      .reset(reset),
      .load(load),
      .addr_in(addr_in),
      .addr_out(addr_out),
      .data_in(data_in),
      .reg_out_select(reg_out_select),
      .e_PC(e_PC),
      .e_IR(e_IR),
      .e_HI(e_HI),
      .e_LO(e_LO),
      .e_ZHI(e_ZHI),
      .e_ZLO(e_ZLO),
      .e_MDR(e_MDR),
`ifdef CPU_TOP_PC_INC_EN
      .inc_pc(inc_pc),
`endif
      .bus_out(bus_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      load = 1'b0;
      e_PC = 1'b0; e_IR = 1'b0; e_HI = 1'b0; e_LO = 1'b0;
      e_ZHI = 1'b0; e_ZLO = 1'b0; e_MDR = 1'b0;
`ifdef CPU_TOP_PC_INC_EN
      inc_pc = 1'b0;
`endif
   endtask

   task automatic rd(input logic [4:0] sel, input logic [3:0] ra, output logic [31:0] v);
      reg_out_select = sel;
      addr_out = ra;
      #1;
      v = bus_out;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      clear_ctl();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      for (int s = 0; s < 32; s++) begin
         if (s == 23) continue;
         rd(5'(s), 4'(s % 16), v);
         total_cnt++;
         if (v !== 32'h0) $display("FAIL reset_sel%0d got %h exp %h", s, v, 32'h0);
         else pass_cnt++;
      end
   endtask

   task automatic test_gpr();
      logic [31:0] v;
      load = 1'b1; addr_in = 4'd0; data_in = 32'hDEADBEEF;
      tick();
      addr_in = 4'd1; data_in = 32'hFACECAFE;
      tick();
      addr_in = 4'd2; data_in = 32'h01234567;
      // pending write to R2 must not be visible before the edge
      rd(5'd0, 4'd2, v);
      total_cnt++;
      if (v !== 32'h0) $display("FAIL no_bypass got %h exp %h", v, 32'h0); else pass_cnt++;
      tick();
      load = 1'b0;
      rd(5'd0, 4'd0, v);
      total_cnt++;
      if (v !== 32'hDEADBEEF) $display("FAIL gpr_r0 got %h exp %h", v, 32'hDEADBEEF); else pass_cnt++;
      rd(5'd1, 4'd1, v);
      total_cnt++;
      if (v !== 32'hFACECAFE) $display("FAIL gpr_r1 got %h exp %h", v, 32'hFACECAFE); else pass_cnt++;
      rd(5'd5, 4'd1, v);
      total_cnt++;
      if (v !== 32'hFACECAFE) $display("FAIL gpr_sel5_r1 got %h exp %h", v, 32'hFACECAFE); else pass_cnt++;
      rd(5'd15, 4'd2, v);
      total_cnt++;
      if (v !== 32'h01234567) $display("FAIL gpr_r2 got %h exp %h", v, 32'h01234567); else pass_cnt++;
   endtask

   task automatic test_special();
      logic [31:0] v;
      clear_ctl(); e_PC = 1'b1; data_in = 32'h12345678; tick();
      clear_ctl(); e_IR = 1'b1; data_in = 32'hCAFEBABE; tick();
      clear_ctl(); e_MDR = 1'b1; data_in = 32'h0BADF00D; tick();
      clear_ctl(); e_ZHI = 1'b1; data_in = 32'h11112222; tick();
      clear_ctl(); e_ZLO = 1'b1; data_in = 32'h33334444; tick();
      clear_ctl();
      rd(5'd20, 4'd0, v);
      total_cnt++;
      if (v !== 32'h12345678) $display("FAIL pc got %h exp %h", v, 32'h12345678); else pass_cnt++;
      rd(5'd21, 4'd0, v);
      total_cnt++;
      if (v !== 32'hCAFEBABE) $display("FAIL ir got %h exp %h", v, 32'hCAFEBABE); else pass_cnt++;
      rd(5'd22, 4'd0, v);
      total_cnt++;
      if (v !== 32'h0BADF00D) $display("FAIL mdr got %h exp %h", v, 32'h0BADF00D); else pass_cnt++;
      rd(5'd18, 4'd0, v);
      total_cnt++;
      if (v !== 32'h11112222) $display("FAIL zhi got %h exp %h", v, 32'h11112222); else pass_cnt++;
      rd(5'd19, 4'd0, v);
      total_cnt++;
      if (v !== 32'h33334444) $display("FAIL zlo got %h exp %h", v, 32'h33334444); else pass_cnt++;
      rd(5'd16, 4'd0, v);
      total_cnt++;
      if (v !== 32'h0) $display("FAIL hi_untouched got %h exp %h", v, 32'h0); else pass_cnt++;
      rd(5'd0, 4'd0, v);
      total_cnt++;
      if (v !== 32'hDEADBEEF) $display("FAIL r0_unchanged got %h exp %h", v, 32'hDEADBEEF); else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      logic [31:0] v;
      clear_ctl();
      load = 1'b1; addr_in = 4'd3; e_HI = 1'b1; e_LO = 1'b1; data_in = 32'hA5A5A5A5;
      tick();
      clear_ctl();
      data_in = 32'h5A5A0F0F;
      rd(5'd3, 4'd3, v);
      total_cnt++;
      if (v !== 32'hA5A5A5A5) $display("FAIL sim_r3 got %h exp %h", v, 32'hA5A5A5A5); else pass_cnt++;
      rd(5'd16, 4'd0, v);
      total_cnt++;
      if (v !== 32'hA5A5A5A5) $display("FAIL sim_hi got %h exp %h", v, 32'hA5A5A5A5); else pass_cnt++;
      rd(5'd17, 4'd0, v);
      total_cnt++;
      if (v !== 32'hA5A5A5A5) $display("FAIL sim_lo got %h exp %h", v, 32'hA5A5A5A5); else pass_cnt++;
      rd(5'd18, 4'd0, v);
      total_cnt++;
      if (v !== 32'h11112222) $display("FAIL sim_zhi_kept got %h exp %h", v, 32'h11112222); else pass_cnt++;
      rd(5'd23, 4'd0, v);
      total_cnt++;
      if (v !== 32'h5A5A0F0F) $display("FAIL inport got %h exp %h", v, 32'h5A5A0F0F); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      logic [31:0] v;
      reset = 1'b0;
      load = 1'b1; addr_in = 4'd7;
      e_PC = 1'b1; e_IR = 1'b1; e_HI = 1'b1; e_LO = 1'b1;
      e_ZHI = 1'b1; e_ZLO = 1'b1; e_MDR = 1'b1;
      data_in = 32'hFFFFFFFF;
      tick();
      reset = 1'b1;
      clear_ctl();
      for (int a = 0; a < 16; a++) begin
         rd(5'd0, 4'(a), v);
         total_cnt++;
         if (v !== 32'h0) $display("FAIL mid_reset_r%0d got %h exp %h", a, v, 32'h0); else pass_cnt++;
      end
      for (int s = 16; s < 23; s++) begin
         rd(5'(s), 4'd0, v);
         total_cnt++;
         if (v !== 32'h0) $display("FAIL mid_reset_sel%0d got %h exp %h", s, v, 32'h0); else pass_cnt++;
      end
      rd(5'd23, 4'd0, v);
      total_cnt++;
      if (v !== 32'hFFFFFFFF) $display("FAIL mid_reset_inport got %h exp %h", v, 32'hFFFFFFFF); else pass_cnt++;
      rd(5'd30, 4'd0, v);
      total_cnt++;
      if (v !== 32'h0) $display("FAIL mid_reset_sel30 got %h exp %h", v, 32'h0); else pass_cnt++;
   endtask

`ifdef CPU_TOP_PC_INC_EN
   task automatic test_pc_inc();
      logic [31:0] v;
      clear_ctl(); e_PC = 1'b1; data_in = 32'hFFFFFFFE; tick();
      clear_ctl(); inc_pc = 1'b1; data_in = 32'h0;
      tick();
      rd(5'd20, 4'd0, v);
      total_cnt++;
      if (v !== 32'hFFFFFFFF) $display("FAIL pc_inc1 got %h exp %h", v, 32'hFFFFFFFF); else pass_cnt++;
      tick();
      rd(5'd20, 4'd0, v);
      total_cnt++;
      if (v !== 32'h0) $display("FAIL pc_inc_wrap got %h exp %h", v, 32'h0); else pass_cnt++;
      e_PC = 1'b1; data_in = 32'h00000010;
      tick();
      clear_ctl();
      rd(5'd20, 4'd0, v);
      total_cnt++;
      if (v !== 32'h00000010) $display("FAIL pc_load_override got %h exp %h", v, 32'h00000010); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_gpr();
      test_special();
      test_simultaneous();
      test_mid_reset();
`ifdef CPU_TOP_PC_INC_EN
      test_pc_inc();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
